handshake_top: RTL and testbench

- Elastic (valid/ready) dataflow kernel: accepts a 64-bit operand `n` together with a control token, and computes the triangular sum S(n) = 0+1+…+(n-1) with a sequential loop.
- Emits the 64-bit result together with a completion control token.
- Sits as the top-level compute unit behind handshake channels. One invocation is in flight at a time.

---
 rtl/handshake_top.sv | 125 ++++++++++++
 tb/tb_handshake_top.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_top.sv
`timescale 1ns/1ps
// Elastic triangular-sum kernel.
// Joins an operand `n` with a start token, computes S(n) = 0+1+...+(n-1) with
// a one-add-per-cycle loop, then forks the result and a done token onto two
// independent output channels. Only one invocation is in flight at a time.
module handshake_top #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  in0_valid,
  output logic                  in0_ready,
  input  logic [DATA_WIDTH-1:0] in0_data,

  input  logic                  inCtrl_valid,
  output logic                  inCtrl_ready,

  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [DATA_WIDTH-1:0] out0_data,

  output logic                  outCtrl_valid,
  input  logic                  outCtrl_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] n_q;       // latched loop bound
  logic [DATA_WIDTH-1:0] acc;       // running sum, also the result
  logic [DATA_WIDTH-1:0] cnt;       // loop index i
  logic [DATA_WIDTH-1:0] cnt_next;
  logic                  sent0;     // result already handed over
  logic                  sent_c;    // done token already handed over

  logic                  join_en;
  logic                  accept;
  logic                  fire0;
  logic                  fire_c;
  logic                  done0;
  logic                  done_c;

  // NOTE: the join readies are combinational on the partner's valid, so they
  // are also qualified by reset; otherwise they could rise while reset is held
  // with both producers already valid.
  assign join_en      = (state == IDLE) && reset;
  assign in0_ready    = join_en && inCtrl_valid;
  assign inCtrl_ready = join_en && in0_valid;
  assign accept       = join_en && in0_valid && inCtrl_valid;

  // Eager fork: each output channel is valid until its own transfer.
  assign out0_valid    = (state == OUT) && !sent0;
  assign outCtrl_valid = (state == OUT) && !sent_c;
  assign out0_data     = acc;

  assign fire0  = out0_valid && out0_ready;
  assign fire_c = outCtrl_valid && outCtrl_ready;

  // A channel counts as finished if it transferred earlier or transfers now.
  assign done0  = sent0 || fire0;
  assign done_c = sent_c || fire_c;

  assign cnt_next = cnt + DATA_WIDTH'(1);

  // Control FSM together with its datapath registers.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others (acc uses the old cnt).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      n_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      sent0  <= 1'b0;
      sent_c <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            n_q   <= in0_data;
            acc   <= '0;
            cnt   <= '0;
            // n == 0 has an empty sum, so skip the loop entirely.
            state <= (in0_data == '0) ? OUT : LOOP;
          end
        end

        LOOP: begin
          acc <= acc + cnt;
          cnt <= cnt_next;
          // Leaving when the incremented index reaches n gives exactly n
          // loop cycles.
          if (cnt_next == n_q) begin
            state <= OUT;
          end
        end

        OUT: begin
          if (done0 && done_c) begin
            sent0  <= 1'b0;
            sent_c <= 1'b0;
            state  <= IDLE;
          end else begin
            if (fire0) begin
              sent0 <= 1'b1;
            end
            if (fire_c) begin
              sent_c <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_top.sv
`timescale 1ns/1ps
// Directed bench for handshake_top: reset state, join behaviour, sums and
// latency for several n, output back-pressure, and reset during the loop.
module tb_handshake_top;

  localparam int DW = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in0_valid = 1'b0;
  logic          in0_ready;
  logic [DW-1:0] in0_data = '0;
  logic          inCtrl_valid = 1'b0;
  logic          inCtrl_ready;
  logic          out0_valid;
  logic          out0_ready = 1'b1;
  logic [DW-1:0] out0_data;
  logic          outCtrl_valid;
  logic          outCtrl_ready = 1'b1;

  int vectors     = 0;
  int miscompares = 0;
  int xfer0       = 0;   // result transfers seen
  int xferc       = 0;   // done-token transfers seen

  handshake_top #(.DATA_WIDTH(DW)) dut (
    .clock         (clock),
    .reset         (reset),
    .in0_valid     (in0_valid),
    .in0_ready     (in0_ready),
    .in0_data      (in0_data),
    .inCtrl_valid  (inCtrl_valid),
    .inCtrl_ready  (inCtrl_ready),
    .out0_valid    (out0_valid),
    .out0_ready    (out0_ready),
    .out0_data     (out0_data),
    .outCtrl_valid (outCtrl_valid),
    .outCtrl_ready (outCtrl_ready)
  );

  always #5 clock = ~clock;

  // Count output transfers on the edges where they happen.
  always @(posedge clock) begin
    if (reset) begin
      if (out0_valid && out0_ready)       xfer0 = xfer0 + 1;
      if (outCtrl_valid && outCtrl_ready) xferc = xferc + 1;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present n with the start token; both must be accepted on the next edge.
  task automatic send(input logic [DW-1:0] n);
    @(negedge clock);
    in0_data     = n;
    in0_valid    = 1'b1;
    inCtrl_valid = 1'b1;
    #1;
    check("join_in0_ready", in0_ready, 1);
    check("join_ctrl_ready", inCtrl_ready, 1);
    @(posedge clock);
    #1;
    in0_valid    = 1'b0;
    inCtrl_valid = 1'b0;
    in0_data     = '0;
  endtask

  // Count edges after the accept edge until out0_valid is seen.
  task automatic wait_valid(input int exp_lat);
    int lat;
    lat = 0;
    @(negedge clock);
    while (!out0_valid && lat < 1000) begin
      @(negedge clock);
      lat = lat + 1;
    end
    check("latency", lat, exp_lat);
  endtask

  // Full invocation with both output readies high.
  task automatic run(input logic [DW-1:0] n, input logic [DW-1:0] exp);
    int b0, bc;
    send(n);
    wait_valid(int'(n));
    b0 = xfer0;
    bc = xferc;
    check("out0_valid", out0_valid, 1);
    check("outCtrl_valid", outCtrl_valid, 1);
    check("out0_data", out0_data, exp);
    @(negedge clock);
    check("out0_valid_drop", out0_valid, 0);
    check("outCtrl_valid_drop", outCtrl_valid, 0);
    check("out0_xfers", xfer0 - b0, 1);
    check("outCtrl_xfers", xferc - bc, 1);
  endtask

  initial begin
    int b0, bc, seen;

    // Reset held with both producers valid: nothing may be ready or valid.
    in0_valid    = 1'b1;
    inCtrl_valid = 1'b1;
    in0_data     = 64'd9;
    #1;
    check("rst_in0_ready", in0_ready, 0);
    check("rst_ctrl_ready", inCtrl_ready, 0);
    check("rst_out0_valid", out0_valid, 0);
    check("rst_outCtrl_valid", outCtrl_valid, 0);
    check("rst_out0_data", out0_data, 0);
    @(negedge clock);
    in0_valid    = 1'b0;
    inCtrl_valid = 1'b0;
    in0_data     = '0;
    @(negedge clock);
    reset = 1'b1;

    // n = 0 then n = 24: exactly two results.
    run(64'd0, 64'd0);
    run(64'd24, 64'd276);
    check("two_results", xfer0, 2);
    run(64'd5, 64'd10);
    run(64'd1, 64'd0);

    // Join: a lone operand is never consumed.
    @(negedge clock);
    b0 = xfer0;
    in0_data  = 64'd7;
    in0_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("lone_ctrl_ready", inCtrl_ready, 1);
      check("lone_in0_ready", in0_ready, 0);
      @(negedge clock);
    end
    check("lone_no_result", xfer0 - b0, 0);
    inCtrl_valid = 1'b1;
    #1;
    check("join_in0_ready_up", in0_ready, 1);
    @(posedge clock);
    #1;
    in0_valid    = 1'b0;
    inCtrl_valid = 1'b0;
    in0_data     = '0;
    wait_valid(7);
    check("join_data", out0_data, 64'd21);
    check("join_ctrl_valid", outCtrl_valid, 1);
    @(negedge clock);
    check("join_valid_drop", out0_valid, 0);

    // Back-pressure on the result channel only.
    out0_ready = 1'b0;
    send(64'd4);
    wait_valid(4);
    check("bp_out0_valid", out0_valid, 1);
    check("bp_ctrl_valid", outCtrl_valid, 1);
    check("bp_data", out0_data, 64'd6);
    bc = xferc;
    b0 = xfer0;
    @(negedge clock);
    check("bp_ctrl_drop", outCtrl_valid, 0);
    check("bp_ctrl_xfer", xferc - bc, 1);
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", out0_valid, 1);
      check("bp_hold_data", out0_data, 64'd6);
      check("bp_hold_ctrl", outCtrl_valid, 0);
      @(negedge clock);
    end
    check("bp_no_xfer", xfer0 - b0, 0);
    out0_ready = 1'b1;
    @(negedge clock);
    check("bp_out0_drop", out0_valid, 0);
    check("bp_out0_xfer", xfer0 - b0, 1);
    check("bp_ctrl_once", xferc - bc, 1);
    inCtrl_valid = 1'b1;
    #1;
    check("bp_back_idle", in0_ready, 1);
    inCtrl_valid = 1'b0;

    // Reset in the middle of a long loop aborts it.
    b0 = xfer0;
    send(64'd100);
    repeat (10) @(negedge clock);
    check("loop_no_valid", out0_valid, 0);
    in0_valid    = 1'b1;
    inCtrl_valid = 1'b1;
    #1;
    check("loop_in0_ready", in0_ready, 0);
    check("loop_ctrl_ready", inCtrl_ready, 0);
    reset = 1'b0;
    #1;
    check("abort_in0_ready", in0_ready, 0);
    check("abort_ctrl_ready", inCtrl_ready, 0);
    check("abort_out0_valid", out0_valid, 0);
    check("abort_outCtrl_valid", outCtrl_valid, 0);
    check("abort_out0_data", out0_data, 0);
    @(negedge clock);
    in0_valid    = 1'b0;
    inCtrl_valid = 1'b0;
    in0_data     = '0;
    @(negedge clock);
    reset = 1'b1;
    seen = 0;
    repeat (120) begin
      @(negedge clock);
      if (out0_valid || outCtrl_valid) seen = seen + 1;
    end
    check("abort_silent", seen, 0);
    run(64'd3, 64'd3);
    check("abort_one_result", xfer0 - b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
